// File: rtl/fetch_mem_arbiter_if.sv
// Bus bundle between fetch_mem_arbiter, its two requesters and instruction memory.
// Ports: slave = arbiter side, master = requesters/memory side (fetch f_*, aux a_*, mem_*, status).
interface fetch_mem_arbiter_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32
);
   logic                       f_req;
   logic [ADDRESS_WIDTH-1:0]   f_addr;
   logic                       f_flush;
   logic                       f_gnt;
   logic                       f_valid;
   logic [4*DATA_WIDTH-1:0]    f_data;
   logic                       a_req;
   logic [ADDRESS_WIDTH-1:0]   a_addr;
   logic                       a_gnt;
   logic                       a_valid;
   logic [4*DATA_WIDTH-1:0]    a_data;
   logic                       mem_rd_en;
   logic [ADDRESS_WIDTH-1:0]   mem_addr;
   logic                       mem_abort;
   logic [4*DATA_WIDTH-1:0]    mem_dout;
   logic                       mem_dout_valid;
   logic                       busy;
   logic                       err_timeout;

   modport slave (
      input  f_req, f_addr, f_flush, a_req, a_addr,
      input  mem_dout, mem_dout_valid,
      output f_gnt, f_valid, f_data, a_gnt, a_valid, a_data,
      output mem_rd_en, mem_addr, mem_abort, busy, err_timeout
   );

   modport master (
      output f_req, f_addr, f_flush, a_req, a_addr,
      output mem_dout, mem_dout_valid,
      input  f_gnt, f_valid, f_data, a_gnt, a_valid, a_data,
      input  mem_rd_en, mem_addr, mem_abort, busy, err_timeout
   );
endinterface

// File: rtl/fetch_mem_arbiter.sv
// Round-robin arbiter sharing one instruction-memory port between fetch and an aux requester.
// Ports: clk, reset (sync, active-high), bus (fetch_mem_arbiter_if.slave).
// Optional macro FETCH_ARB_TIMEOUT_EN adds a BUSY watchdog limited by TIMEOUT_CYCLES.
module fetch_mem_arbiter #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDRESS_WIDTH  = 32,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic               clk,
   input  logic               reset,
   fetch_mem_arbiter_if.slave bus
);
   localparam int BW = 4 * DATA_WIDTH;

   typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_A} state_t;

   state_t                   state;
   logic                     last_gnt;
   logic [ADDRESS_WIDTH-1:0] addr_q;
   logic [BW-1:0]            f_data_q;
   logic [BW-1:0]            a_data_q;
   logic                     f_gnt_q;
   logic                     a_gnt_q;
   logic                     f_valid_q;
   logic                     a_valid_q;
   logic                     abort_q;
   logic                     f_ok;
   logic                     f_kill;
   logic                     wd_hit;
   logic                     wd_fire;

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 1..255");
   end

   // A redirect in the same cycle as the request cancels it.
   assign f_ok   = bus.f_req && !bus.f_flush;
   assign f_kill = (state == BUSY_F) && bus.f_flush;

`ifdef FETCH_ARB_TIMEOUT_EN
   localparam logic [7:0] WD_LIM = 8'(TIMEOUT_CYCLES);
   localparam logic [7:0] WD_PRE = 8'(TIMEOUT_CYCLES - 1);

   logic [7:0] wd_cnt;
   logic       err_q;

   // wd_fire registers the abort/err pulse; the FSM leaves on the wd_hit cycle.
   assign wd_hit  = (state != IDLE) && (wd_cnt == WD_LIM);
   assign wd_fire = (state != IDLE) && !bus.mem_dout_valid &&
                    !f_kill && (wd_cnt == WD_PRE);

   always_ff @(posedge clk) begin
      if (reset) begin
         wd_cnt <= '0;
         err_q  <= 1'b0;
      end else begin
         err_q <= wd_fire;
         if (state == IDLE)
            wd_cnt <= '0;
         else if (!bus.mem_dout_valid)
            wd_cnt <= wd_cnt + 8'd1;
      end
   end

   assign bus.err_timeout = err_q;
`else
   assign wd_hit          = 1'b0;
   assign wd_fire         = 1'b0;
   assign bus.err_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         last_gnt  <= 1'b1;
         addr_q    <= '0;
         f_data_q  <= '0;
         a_data_q  <= '0;
         f_gnt_q   <= 1'b0;
         a_gnt_q   <= 1'b0;
         f_valid_q <= 1'b0;
         a_valid_q <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         f_gnt_q   <= 1'b0;
         a_gnt_q   <= 1'b0;
         f_valid_q <= 1'b0;
         a_valid_q <= 1'b0;
         abort_q   <= 1'b0;
         unique case (state)
            IDLE: begin
               // last_gnt = 1 means aux went last, so fetch wins a tie.
               if (f_ok && (!bus.a_req || last_gnt)) begin
                  state    <= BUSY_F;
                  f_gnt_q  <= 1'b1;
                  last_gnt <= 1'b0;
                  addr_q   <= {bus.f_addr[ADDRESS_WIDTH-1:2], 2'b00};
               end else if (bus.a_req) begin
                  state    <= BUSY_A;
                  a_gnt_q  <= 1'b1;
                  last_gnt <= 1'b1;
                  addr_q   <= {bus.a_addr[ADDRESS_WIDTH-1:2], 2'b00};
               end
            end
            BUSY_F, BUSY_A: begin
               if (wd_hit) begin
                  state <= IDLE;
               end else if (f_kill) begin
                  abort_q <= 1'b1;
                  state   <= IDLE;
               end else if (bus.mem_dout_valid) begin
                  state <= IDLE;
                  if (state == BUSY_F) begin
                     f_data_q  <= bus.mem_dout;
                     f_valid_q <= 1'b1;
                  end else begin
                     a_data_q  <= bus.mem_dout;
                     a_valid_q <= 1'b1;
                  end
               end else if (wd_fire) begin
                  abort_q <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.f_gnt     = f_gnt_q;
   assign bus.a_gnt     = a_gnt_q;
   assign bus.f_valid   = f_valid_q;
   assign bus.a_valid   = a_valid_q;
   assign bus.f_data    = f_data_q;
   assign bus.a_data    = a_data_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_abort = abort_q;
   assign bus.mem_rd_en = (state != IDLE);
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Self-checking bench for fetch_mem_arbiter: directed steps plus a data scoreboard.
// Build with FETCH_ARB_TIMEOUT_EN to cover the watchdog instead of the no-timeout wait.
module tb_fetch_mem_arbiter;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TO = 3;
   localparam int BW = 4 * DW;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fetch_mem_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

   fetch_mem_arbiter #(
      .DATA_WIDTH(DW),
      .ADDRESS_WIDTH(AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [BW-1:0] fq[$];
   logic [BW-1:0] aq[$];
   logic [BW-1:0] last_f;
   logic [BW-1:0] last_a;
   logic [BW-1:0] d;

   task automatic check(string tag, logic [BW-1:0] obs, logic [BW-1:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [BW-1:0] rnd_blk();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Scoreboard: every valid pulse must match the oldest queued response.
   always @(negedge clk) begin
      if (bus.f_valid === 1'b1) begin
         if (fq.size() == 0)
            check("f_valid_spurious", bus.f_valid, 1'b0);
         else
            check("f_data", bus.f_data, fq.pop_front());
      end
      if (bus.a_valid === 1'b1) begin
         if (aq.size() == 0)
            check("a_valid_spurious", bus.a_valid, 1'b0);
         else
            check("a_data", bus.a_data, aq.pop_front());
      end
   end

   initial begin
      logic ok_busy;
      logic saw_err;
      logic exp_f;

      reset              = 1'b1;
      bus.f_req          = 1'b0;
      bus.f_addr         = '0;
      bus.f_flush        = 1'b0;
      bus.a_req          = 1'b0;
      bus.a_addr         = '0;
      bus.mem_dout       = '0;
      bus.mem_dout_valid = 1'b0;
      last_f             = '0;
      last_a             = '0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_busy", bus.busy, 1'b0);
      check("rst_rd_en", bus.mem_rd_en, 1'b0);
      check("rst_maddr", bus.mem_addr, '0);
      check("rst_abort", bus.mem_abort, 1'b0);
      check("rst_err", bus.err_timeout, 1'b0);
      check("rst_fgnt", bus.f_gnt, 1'b0);
      check("rst_agnt", bus.a_gnt, 1'b0);
      check("rst_fdata", bus.f_data, '0);
      check("rst_adata", bus.a_data, '0);
      reset = 1'b0;

      // Basic fetch, minimum latency, address alignment
      bus.f_req  = 1'b1;
      bus.f_addr = 32'h13;
      @(negedge clk);
      check("t1_fgnt", bus.f_gnt, 1'b1);
      check("t1_agnt", bus.a_gnt, 1'b0);
      check("t1_busy", bus.busy, 1'b1);
      check("t1_rd_en", bus.mem_rd_en, 1'b1);
      check("t1_maddr", bus.mem_addr, 32'h10);
      bus.f_req = 1'b0;
      d = rnd_blk();
      fq.push_back(d);
      last_f             = d;
      bus.mem_dout       = d;
      bus.mem_dout_valid = 1'b1;
      @(negedge clk);
      check("t1_fvalid", bus.f_valid, 1'b1);
      check("t1_fgnt_pulse", bus.f_gnt, 1'b0);
      check("t1_idle", bus.busy, 1'b0);
      check("t1_rd_en_off", bus.mem_rd_en, 1'b0);
      bus.mem_dout_valid = 1'b0;
      bus.mem_dout       = rnd_blk();
      @(negedge clk);
      check("t1_fvalid_pulse", bus.f_valid, 1'b0);
      check("t1_fdata_hold", bus.f_data, last_f);

      // Reset restores last_gnt = aux, so fetch wins the first tie again
      reset = 1'b1;
      @(negedge clk);
      check("t2_rst_fdata", bus.f_data, '0);
      reset      = 1'b0;
      bus.f_req  = 1'b1;
      bus.a_req  = 1'b1;
      bus.f_addr = 32'h100;
      bus.a_addr = 32'h205;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_f = (i % 2 == 0);
         check($sformatf("rr%0d_fgnt", i), bus.f_gnt, exp_f);
         check($sformatf("rr%0d_agnt", i), bus.a_gnt, !exp_f);
         check($sformatf("rr%0d_maddr", i), bus.mem_addr,
               exp_f ? 32'h100 : 32'h204);
         d = rnd_blk();
         if (exp_f) begin
            fq.push_back(d);
            last_f = d;
         end else begin
            aq.push_back(d);
            last_a = d;
         end
         bus.mem_dout       = d;
         bus.mem_dout_valid = 1'b1;
         @(negedge clk);
         check($sformatf("rr%0d_gap", i), bus.busy, 1'b0);
         check($sformatf("rr%0d_fvalid", i), bus.f_valid, exp_f);
         check($sformatf("rr%0d_avalid", i), bus.a_valid, !exp_f);
         bus.mem_dout_valid = 1'b0;
         if (i == 3) begin
            bus.f_req = 1'b0;
            bus.a_req = 1'b0;
         end
      end
      @(negedge clk);
      check("rr_done_idle", bus.busy, 1'b0);

      // Flush beats a simultaneous memory response
      bus.f_req  = 1'b1;
      bus.f_addr = 32'h40;
      @(negedge clk);
      check("t3_fgnt", bus.f_gnt, 1'b1);
      bus.f_req          = 1'b0;
      bus.f_flush        = 1'b1;
      bus.mem_dout       = rnd_blk();
      bus.mem_dout_valid = 1'b1;
      @(negedge clk);
      check("t3_abort", bus.mem_abort, 1'b1);
      check("t3_fvalid", bus.f_valid, 1'b0);
      check("t3_idle", bus.busy, 1'b0);
      check("t3_rd_en", bus.mem_rd_en, 1'b0);
      check("t3_fdata_keep", bus.f_data, last_f);
      bus.f_flush        = 1'b0;
      bus.mem_dout_valid = 1'b0;
      @(negedge clk);
      check("t3_abort_pulse", bus.mem_abort, 1'b0);

      // Flush in IDLE blocks fetch; aux still granted; flush in BUSY_A ignored
      bus.f_req   = 1'b1;
      bus.f_flush = 1'b1;
      @(negedge clk);
      check("t4_nogrant", bus.busy, 1'b0);
      check("t4_nofgnt", bus.f_gnt, 1'b0);
      bus.a_req  = 1'b1;
      bus.a_addr = 32'h3C;
      @(negedge clk);
      check("t4_agnt", bus.a_gnt, 1'b1);
      check("t4_fgnt", bus.f_gnt, 1'b0);
      check("t4_maddr", bus.mem_addr, 32'h3C);
      bus.f_req = 1'b0;
      bus.a_req = 1'b0;
      @(negedge clk);
      check("t4_busy_a", bus.busy, 1'b1);
      check("t4_no_abort", bus.mem_abort, 1'b0);
      check("t4_agnt_pulse", bus.a_gnt, 1'b0);
      bus.f_flush = 1'b0;
      d = rnd_blk();
      aq.push_back(d);
      last_a             = d;
      bus.mem_dout       = d;
      bus.mem_dout_valid = 1'b1;
      @(negedge clk);
      check("t4_avalid", bus.a_valid, 1'b1);
      check("t4_idle", bus.busy, 1'b0);

      // Memory valid in IDLE is ignored
      bus.mem_dout = rnd_blk();
      @(negedge clk);
      check("t5_fvalid", bus.f_valid, 1'b0);
      check("t5_avalid", bus.a_valid, 1'b0);
      check("t5_adata", bus.a_data, last_a);
      bus.mem_dout_valid = 1'b0;

      // Reset while BUSY_A
      bus.a_req  = 1'b1;
      bus.a_addr = 32'h80;
      @(negedge clk);
      check("t6_agnt", bus.a_gnt, 1'b1);
      bus.a_req          = 1'b0;
      reset              = 1'b1;
      bus.mem_dout       = rnd_blk();
      bus.mem_dout_valid = 1'b1;
      @(negedge clk);
      check("t6_busy", bus.busy, 1'b0);
      check("t6_rd_en", bus.mem_rd_en, 1'b0);
      check("t6_avalid", bus.a_valid, 1'b0);
      check("t6_abort", bus.mem_abort, 1'b0);
      check("t6_adata", bus.a_data, '0);
      reset              = 1'b0;
      bus.mem_dout_valid = 1'b0;
      bus.f_req          = 1'b1;
      bus.a_req          = 1'b1;
      bus.f_addr         = 32'h24;
      @(negedge clk);
      check("t6_tie_fgnt", bus.f_gnt, 1'b1);
      check("t6_tie_agnt", bus.a_gnt, 1'b0);
      bus.f_req = 1'b0;
      bus.a_req = 1'b0;
      d = rnd_blk();
      fq.push_back(d);
      last_f             = d;
      bus.mem_dout       = d;
      bus.mem_dout_valid = 1'b1;
      @(negedge clk);
      check("t6_fvalid", bus.f_valid, 1'b1);
      bus.mem_dout_valid = 1'b0;
      @(negedge clk);

`ifdef FETCH_ARB_TIMEOUT_EN
      // Watchdog: silent memory, TIMEOUT_CYCLES = 3
      bus.f_req  = 1'b1;
      bus.f_addr = 32'h200;
      @(negedge clk);
      check("wd_c1_fgnt", bus.f_gnt, 1'b1);
      bus.f_req = 1'b0;
      @(negedge clk);
      check("wd_c2_abort", bus.mem_abort, 1'b0);
      check("wd_c2_busy", bus.busy, 1'b1);
      @(negedge clk);
      check("wd_c3_abort", bus.mem_abort, 1'b0);
      check("wd_c3_err", bus.err_timeout, 1'b0);
      @(negedge clk);
      check("wd_c4_abort", bus.mem_abort, 1'b1);
      check("wd_c4_err", bus.err_timeout, 1'b1);
      check("wd_c4_busy", bus.busy, 1'b1);
      bus.mem_dout       = rnd_blk();
      bus.mem_dout_valid = 1'b1;
      @(negedge clk);
      check("wd_c5_idle", bus.busy, 1'b0);
      check("wd_c5_abort", bus.mem_abort, 1'b0);
      check("wd_c5_err", bus.err_timeout, 1'b0);
      check("wd_c5_fvalid", bus.f_valid, 1'b0);
      bus.mem_dout_valid = 1'b0;
      @(negedge clk);
`else
      // No watchdog: BUSY holds through a long silent memory
      bus.a_req  = 1'b1;
      bus.a_addr = 32'h300;
      @(negedge clk);
      check("nowd_agnt", bus.a_gnt, 1'b1);
      bus.a_req = 1'b0;
      ok_busy   = 1'b1;
      saw_err   = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (bus.busy !== 1'b1) ok_busy = 1'b0;
         if (bus.err_timeout !== 1'b0) saw_err = 1'b1;
      end
      check("nowd_busy", ok_busy, 1'b1);
      check("nowd_err", saw_err, 1'b0);
      d = rnd_blk();
      aq.push_back(d);
      bus.mem_dout       = d;
      bus.mem_dout_valid = 1'b1;
      @(negedge clk);
      check("nowd_avalid", bus.a_valid, 1'b1);
      bus.mem_dout_valid = 1'b0;
      @(negedge clk);
`endif

      check("fq_empty", fq.size(), 0);
      check("aq_empty", aq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/fetch_mem_arbiter.md
FETCH_MEM_ARBITER -- requirements
Module: fetch_mem_arbiter

Interface
REQ-001 Parameters: DATA_WIDTH, default 32, instruction word width; ADDRESS_WIDTH, default 32, address width; TIMEOUT_CYCLES, default 15, range 1..255, watchdog limit.
REQ-002 Clocking: one clock, clk; reset is synchronous and active-high, named reset.
REQ-003 clk  input  1  clock, all state updates on its rising edge.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 f_req  input  1  fetch requester wants a 4-instruction block.
REQ-006 f_addr  input  ADDRESS_WIDTH  fetch address, instruction granularity.
REQ-007 f_flush  input  1  fetch redirect (jump/branch); kills the pending fetch transaction.
REQ-008 f_gnt / f_valid  output  1 each  fetch accepted pulse / fetch data valid pulse.
REQ-009 f_data  output  4*DATA_WIDTH  fetched block.
REQ-010 a_req  input  1, a_addr  input  ADDRESS_WIDTH  auxiliary requester (debug/loader) request and address.
REQ-011 a_gnt / a_valid  output  1 each, a_data  output  4*DATA_WIDTH  auxiliary accept pulse, data valid pulse, block.
REQ-012 mem_rd_en  output  1, mem_addr  output  ADDRESS_WIDTH, mem_abort  output  1  instruction-memory port controls.
REQ-013 mem_dout  input  4*DATA_WIDTH, mem_dout_valid  input  1  memory block and its valid.
REQ-014 busy  output  1  high in any non-IDLE state; err_timeout  output  1  watchdog pulse.

Function
REQ-015 FSM states: IDLE, BUSY_F, BUSY_A; next state registered.
REQ-016 IDLE: only f_req -> BUSY_F; only a_req -> BUSY_A; both -> requester not granted last (round-robin via last_gnt bit); neither -> stay IDLE.
REQ-017 On entering BUSY_x, the selected address is latched; mem_addr = {addr[ADDRESS_WIDTH-1:2],2'b00}.
REQ-018 x_gnt is a one-cycle pulse in the first BUSY_x cycle; requester may drop x_req after seeing it.
REQ-019 mem_rd_en is high in every BUSY cycle and low in IDLE.
REQ-020 mem_dout_valid high in BUSY_x: mem_dout captured into x_data, x_valid pulses one cycle on the next cycle, FSM returns to IDLE.
REQ-021 Minimum latency: x_req sampled at edge N, mem_dout_valid in cycle N+1 gives x_valid in cycle N+2.
REQ-022 At least one IDLE cycle separates consecutive transactions; a held x_req is treated as a new request.
REQ-023 x_data holds its last value until overwritten; it is not cleared after x_valid.
REQ-024 f_flush in BUSY_F: mem_abort pulses one cycle, FSM goes to IDLE, and no f_valid is produced, even if mem_dout_valid is in the same cycle (flush wins).
REQ-025 f_flush in IDLE with f_req in the same cycle: fetch is not accepted; a_req, if present, is granted.
REQ-026 f_flush in BUSY_A has no effect; mem_dout_valid in IDLE is ignored.
REQ-027 last_gnt updates only on entry into BUSY_x.

Reset
REQ-028 Reset leaves the FSM in IDLE with last_gnt = auxiliary, so fetch wins the first tie.
REQ-029 Reset zeroes all outputs, f_data, a_data, latched address and watchdog counter.
REQ-030 Reset mid-transaction: mem_rd_en is low the next cycle, no abort pulse is issued, and no valid is produced.

Configuration
REQ-031 With FETCH_ARB_TIMEOUT_EN defined, an 8-bit counter clears on BUSY entry and increments each BUSY cycle without mem_dout_valid.
REQ-032 When the counter reaches TIMEOUT_CYCLES: mem_abort and err_timeout pulse one cycle, FSM returns to IDLE, and no valid is produced.
REQ-033 Without FETCH_ARB_TIMEOUT_EN, no counter exists, BUSY waits indefinitely, and err_timeout is tied to 0.

Verification
REQ-034 f_req, f_addr=0x13, memory valid 1 cycle after mem_rd_en -> mem_addr=0x10, f_gnt at N+1, f_valid at N+2 with f_data=mem_dout.
REQ-035 f_req and a_req held high for 4 transactions after reset -> grant order F,A,F,A with one IDLE cycle between each.
REQ-036 f_flush in the same cycle as mem_dout_valid in BUSY_F -> mem_abort=1, f_valid stays 0, IDLE next cycle.
REQ-037 Macro on, TIMEOUT_CYCLES=3, memory silent -> err_timeout and mem_abort pulse in the 4th BUSY cycle, then IDLE.
REQ-038 Macro off, memory silent for 300 cycles -> busy remains 1, err_timeout stays 0.
REQ-039 reset asserted in BUSY_A -> next cycle busy=0, mem_rd_en=0, a_valid=0, and the next tie grants fetch.
